// File: rtl/load_store_unit.sv
// Load/store unit: turns one CPU word/half/byte access into a sequence of
// single-byte memory strobes, with sign/zero extension of load results.
module load_store_unit #(
  parameter int unsigned ADDR_LIMIT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t      state;
  logic [2:0]  ctrl;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  idx;
  logic [31:0] result;
  logic        pend;
  logic [1:0]  pidx;

  logic [2:0]  req_n;
  logic [32:0] req_end;
  logic        req_err;
  logic [1:0]  last_idx;
  logic [1:0]  next_idx;
  logic [31:0] merged;
  logic [31:0] ext;

  assign req_ready = (state == IDLE);
  assign last_idx  = ctrl[1] ? 2'd3 : (ctrl[0] ? 2'd1 : 2'd0);
  assign next_idx  = idx + 2'd1;

  // Range check at 33 bits so an access wrapping past 2^32 is rejected.
  always_comb begin
    req_n = 3'd1;
    case (req_ctrl[1:0])
      2'b01:   req_n = 3'd2;
      2'b10:   req_n = 3'd4;
      default: req_n = 3'd1;
    endcase
    req_end = {1'b0, req_addr} + {30'b0, req_n} - 33'd1;
    req_err = (req_ctrl == 3'b011) || (req_ctrl[2:1] == 2'b11) ||
              (req_end >= 33'(ADDR_LIMIT));
  end

  // The byte returning this cycle is merged in so DRAIN can respond directly.
  always_comb begin
    merged = result;
    if (pend) merged[{pidx, 3'b000} +: 8] = mem_rdata;
    case (ctrl)
      3'b000:  ext = {{24{merged[7]}}, merged[7:0]};
      3'b001:  ext = {{16{merged[15]}}, merged[15:0]};
      3'b100:  ext = {24'b0, merged[7:0]};
      3'b101:  ext = {16'b0, merged[15:0]};
      default: ext = merged;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ctrl      <= '0;
      we        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      idx       <= '0;
      result    <= '0;
      pend      <= 1'b0;
      pidx      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pend      <= 1'b0;
      if (pend) result[{pidx, 3'b000} +: 8] <= mem_rdata;

      case (state)
        IDLE: begin
          if (req_valid) begin
            ctrl   <= req_ctrl;
            we     <= req_we;
            addr   <= req_addr;
            wdata  <= req_wdata;
            idx    <= '0;
            result <= '0;
            if (req_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state     <= ISSUE;
              mem_en    <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata[7:0];
            end
          end
        end
        ISSUE: begin
          pend <= !we;
          pidx <= idx;
          if (idx == last_idx) begin
            if (we) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            idx       <= next_idx;
            mem_en    <= 1'b1;
            mem_we    <= we;
            mem_addr  <= addr + {30'b0, idx} + 32'd1;
            mem_wdata <= wdata[{next_idx, 3'b000} +: 8];
          end
        end
        DRAIN: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= ext;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte memory model plus a reference model working
// at the level of whole accesses (byte count, latency, little-endian value).
module tb_load_store_unit;

  localparam int unsigned LIMIT = 4096;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  bit [7:0] tbmem [LIMIT];
  bit [7:0] ref_mem [LIMIT];
  int checks = 0;
  int fails  = 0;

  load_store_unit #(.ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tbmem[mem_addr[11:0]] <= mem_wdata;
      else        mem_rdata <= tbmem[mem_addr[11:0]];
    end
  end

  // Issues one access starting at a negedge in IDLE; returns at the negedge
  // of the following IDLE cycle.
  task automatic do_req(input logic w, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] d, input bit hammer, output logic [31:0] rd);
    int unsigned n, lat_exp, v, b, nstb, lat;
    bit err, got;
    logic [31:0] exp_rd;
    longint unsigned last;
    case (c)
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    n = 1;
    endcase
    last = longint'(a) + n - 1;
    err = (c == 3'd3) || (c == 3'd6) || (c == 3'd7) || (last >= LIMIT);
    lat_exp = err ? 1 : (w ? n + 1 : n + 2);
    v = 0;
    if (!err) for (int i = 0; i < int'(n); i++) begin
      b = ref_mem[a + i];
      v += b << (8 * i);
    end
    exp_rd = v;
    if (c == 3'd0 && v >= 128)   exp_rd = v + 32'hFFFFFF00;
    if (c == 3'd1 && v >= 32768) exp_rd = v + 32'hFFFF0000;
    if (err || w) exp_rd = '0;

    req_valid = 1'b1; req_we = w; req_ctrl = c; req_addr = a; req_wdata = d;
    checks++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL ready_before_accept got %b want 1", req_ready); end
    @(posedge clk); #1;
    if (!err && w) for (int i = 0; i < int'(n); i++) ref_mem[a + i] = d[8*i +: 8];
    req_valid = hammer; req_we = $urandom; req_ctrl = $urandom;
    req_addr = $urandom; req_wdata = $urandom;

    nstb = 0; got = 0; lat = 0; rd = '0;
    for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin fails++; $display("FAIL ready_busy cyc %0d got %b want 0", cyc, req_ready); end
      if (mem_en === 1'b1) begin
        checks++;
        if (cyc != int'(nstb) + 1 || mem_addr !== a + nstb || mem_we !== w ||
            (w && mem_wdata !== d[8*nstb +: 8])) begin
          fails++;
          $display("FAIL strobe cyc %0d addr %h we %b data %h want cyc %0d addr %h we %b data %h",
                   cyc, mem_addr, mem_we, mem_wdata, nstb + 1, a + nstb, w, d[8*nstb +: 8]);
        end
        nstb++;
      end
      if (rsp_valid === 1'b1) begin
        got = 1; lat = cyc; rd = rsp_rdata;
        checks++;
        if (rsp_err !== err || rsp_rdata !== exp_rd) begin
          fails++;
          $display("FAIL response err %b data %h want err %b data %h (we %b ctrl %0d addr %h)",
                   rsp_err, rsp_rdata, err, exp_rd, w, c, a);
        end
      end
      if (hammer) begin
        req_we = $urandom; req_ctrl = $urandom; req_addr = $urandom; req_wdata = $urandom;
      end
    end
    checks++;
    if (!got || lat != lat_exp) begin fails++; $display("FAIL latency got %0d want %0d (responded %b)", lat, lat_exp, got); end
    checks++;
    if (nstb != (err ? 0 : n)) begin fails++; $display("FAIL strobe_count got %0d want %0d", nstb, err ? 0 : n); end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0 || mem_en !== 1'b0) begin
      fails++;
      $display("FAIL back_to_idle ready %b rsp_valid %b rdata %h err %b mem_en %b want 1 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_ctrl = '0; req_addr = '0; req_wdata = '0;
    #12;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0 ||
        mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      fails++;
      $display("FAIL reset_state ready %b rv %b rd %h err %b en %b we %b addr %h wd %h want 1 0 0 0 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word();
    logic [31:0] rd;
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, rd);
    checks++;
    if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_value got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd;
    do_req(1'b1, 3'd4, 32'h20, 32'h12345680, 0, rd);
    do_req(1'b0, 3'd0, 32'h20, 32'h0, 0, rd);
    checks++;
    if (rd !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_value got %h want ffffff80", rd); end
    do_req(1'b0, 3'd4, 32'h20, 32'h0, 0, rd);
    checks++;
    if (rd !== 32'h00000080) begin fails++; $display("FAIL lbu_value got %h want 00000080", rd); end
    do_req(1'b1, 3'd5, 32'h30, 32'hAAAA9234, 0, rd);
    do_req(1'b0, 3'd1, 32'h30, 32'h0, 0, rd);
    checks++;
    if (rd !== 32'hFFFF9234) begin fails++; $display("FAIL lh_value got %h want ffff9234", rd); end
    do_req(1'b0, 3'd5, 32'h30, 32'h0, 0, rd);
    checks++;
    if (rd !== 32'h00009234) begin fails++; $display("FAIL lhu_value got %h want 00009234", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    do_req(1'b0, 3'd3, 32'h40, 32'h0, 0, rd);
    do_req(1'b0, 3'd2, 32'hFFD, 32'h0, 0, rd);
    do_req(1'b0, 3'd2, 32'hFFFFFFFE, 32'h0, 0, rd);
    do_req(1'b1, 3'd7, 32'h0, 32'h1, 0, rd);
    do_req(1'b1, 3'd2, 32'hFFC, 32'hCAFEF00D, 0, rd);
    do_req(1'b0, 3'd2, 32'hFFC, 32'h0, 0, rd);
    do_req(1'b0, 3'd4, 32'hFFF, 32'h0, 0, rd);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    req_valid = 1'b1; req_we = 1'b1; req_ctrl = 3'd2; req_addr = 32'h50; req_wdata = 32'h11223344;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h51) begin fails++; $display("FAIL second_strobe en %b addr %h want 1 00000051", mem_en, mem_addr); end
    rst_n = 1'b0; #1;
    checks++;
    if (mem_en !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL async_abort en %b ready %b rv %b want 0 1 0", mem_en, req_ready, rsp_valid);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL held_reset en %b rv %b want 0 0", mem_en, rsp_valid); end
    end
    rst_n = 1'b1;
    ref_mem[32'h50] = 8'h44;
    do_req(1'b0, 3'd0, 32'h50, 32'h0, 0, rd);
    checks++;
    if (rd !== 32'h00000044) begin fails++; $display("FAIL lb_after_reset got %h want 00000044", rd); end
  endtask

  task automatic test_busy();
    logic [31:0] rd;
    do_req(1'b1, 3'd2, 32'h60, 32'h89ABCDEF, 1, rd);
    do_req(1'b0, 3'd2, 32'h60, 32'h0, 1, rd);
    do_req(1'b0, 3'd1, 32'h62, 32'h0, 0, rd);
  endtask

  task automatic test_random();
    logic [31:0] rd, a;
    for (int i = 0; i < 80; i++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 255);
      do_req(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, bit'($urandom_range(0, 3) == 0), rd);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_reset_mid();
    test_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The parameter list SHALL be: ADDR_LIMIT, 4096, byte size of the attached data memory; accesses must satisfy addr+N-1 < ADDR_LIMIT.
REQ-002 The ports SHALL be, in order:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  CPU access request.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_ctrl  in  3  000 byte, 001 half, 010 word, 100 unsigned byte, 101 unsigned half.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data.
- rsp_err  out  1  request rejected.
- mem_en  out  1  byte-memory strobe.
- mem_we  out  1  byte write enable.
- mem_addr  out  32  byte address to memory.
- mem_wdata  out  8  byte to write.
- mem_rdata  in  8  byte read; valid the cycle after a read strobe.

Function
REQ-003 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_ctrl, req_we, req_addr and req_wdata SHALL be latched at that edge.
REQ-004 req_ready SHALL be 1 only in state IDLE.
REQ-005 The byte count N SHALL be 1 for ctrl 000/100, 2 for 001/101 and 4 for 010.
REQ-006 ctrl 011/110/111, or addr+N-1 >= ADDR_LIMIT computed at 33-bit width (so 32-bit wrap is an error), SHALL be an error.
REQ-007 An error request SHALL issue no mem_en and SHALL pulse rsp_valid=1, rsp_err=1, rsp_rdata=0 in the cycle after acceptance.
REQ-008 The FSM SHALL have the states IDLE, ISSUE, DRAIN and RESP.
- IDLE -> ISSUE on a legal accept.
- IDLE -> RESP on an error accept.
- ISSUE -> RESP after N strobes for a store; ISSUE -> DRAIN after N strobes for a load.
- DRAIN -> RESP.
- RESP -> IDLE.
REQ-009 In ISSUE, byte i (0..N-1) SHALL be strobed in consecutive cycles with mem_en=1, mem_addr=addr+i, mem_we=req_we and mem_wdata=wdata[8i+7:8i] (little-endian).
REQ-010 Store latency SHALL be N cycles of strobes starting the cycle after acceptance, with rsp_valid in cycle N+1 after acceptance.
REQ-011 Load data for byte i SHALL be captured from mem_rdata one cycle after its strobe into result bits [8i+7:8i]; DRAIN captures the last byte, giving rsp_valid in cycle N+2 after acceptance.
REQ-012 Load results SHALL be extended as follows: ctrl 000 sign-extends bit 7, 001 sign-extends bit 15, 100/101 zero-extend, 010 takes the full word.
REQ-013 ctrl 100/101 on a store SHALL behave as 000/001 (sb/sh).
REQ-014 rsp_valid SHALL be high exactly one cycle (RESP), with no backpressure; rsp_rdata and rsp_err SHALL be 0 for stores and hold their value only during RESP, otherwise 0.
REQ-015 mem_en, mem_we, mem_addr and mem_wdata SHALL be 0 outside ISSUE.
REQ-016 req_valid while not ready SHALL be ignored, and inputs changing after acceptance SHALL have no effect.
REQ-017 A new request SHALL be accepted no earlier than the cycle after RESP (IDLE), so back-to-back throughput is N+2 cycles per store and N+3 per load.

Reset
REQ-018 While rst_n=0, the unit SHALL immediately hold the state at IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0, and clear all internal registers.
REQ-019 Reset asserted mid-access SHALL abort the access with no further strobes and no response; the first edge after release SHALL see IDLE.

Verification
REQ-020 Word store then word load: sw addr 0x10, data 0xDEADBEEF -> strobes (0x10,EF),(0x11,BE),(0x12,AD),(0x13,DE) and rsp_valid in cycle 5; lw 0x10 -> rsp_rdata=0xDEADBEEF in cycle 6.
REQ-021 Signed and unsigned byte load: memory[0x20]=0x80; lb -> 0xFFFFFF80; lbu -> 0x00000080; each with rsp_valid in cycle 3.
REQ-022 Halfword load: memory[0x30..0x31]=0x34,0x92; lh -> 0xFFFF9234; lhu -> 0x00009234.
REQ-023 Errors: ctrl=011 -> rsp_err=1 in cycle 1 with no mem_en; lw at 0xFFD with ADDR_LIMIT=4096 -> error; lw at 0xFFFFFFFE -> error (wrap).
REQ-024 Reset mid-operation: rst_n low during the second strobe of sw -> mem_en=0 immediately, no rsp_valid; after release req_ready=1 and a new lb completes normally.
REQ-025 Busy handling: req_valid held high with changing req_addr during ISSUE -> ignored; the next request is accepted only the cycle after RESP.
